hazard_resolver: RTL and testbench

//  Consumer side of the register-collision interface. Takes the per-stage collision flags from
//  the data collision detector and tracks which EX/DM instructions actually write and which are

---
 rtl/hazard_resolver.sv | 150 +++++++++++++++
 tb/tb_hazard_resolver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_resolver.sv
// hazard_resolver
// Consumer side of the register-collision interface. Combines the detector's
// per-stage collision flags with locally tracked EX/DM write/load status to
// produce operand forwarding selects, the load-use stall/bubble pair and the
// pipeline-advance enable (which also drives the detector's en). A small
// RUN/WAIT FSM freezes the pipeline while a slow load completes in DM.

module hazard_resolver #(
   parameter int MEM_WAIT = 0,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_use_a,
   input  logic       id_use_b,
   input  logic       id_req_a_zero,
   input  logic       id_req_b_zero,
   input  logic       id_wen,
   input  logic       id_is_load,
   input  logic       flush,
   input  logic       ex_collision_a,
   input  logic       dm_collision_a,
   input  logic       ex_collision_b,
   input  logic       dm_collision_b,
   output logic [1:0] fwd_sel_a,
   output logic [1:0] fwd_sel_b,
   output logic       stall,
   output logic       bubble,
   output logic       pipe_en
);

   localparam logic [0:0]       ST_RUN     = 1'b0;
   localparam logic [0:0]       ST_WAIT    = 1'b1;
   localparam logic [CNT_W-1:0] MEM_WAIT_C = CNT_W'(MEM_WAIT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

   logic             ex_wen_q,   ex_wen_d;
   logic             ex_load_q,  ex_load_d;
   logic             dm_wen_q,   dm_wen_d;
   logic             dm_load_q,  dm_load_d;
   logic [0:0]       state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;

   logic hit_ex_a_s, hit_dm_a_s, hit_ex_b_s, hit_dm_b_s;
   logic run_s, lu_s, kill_s;

   // A hit needs a real read of a non-$0 register that a live writer targets.
   assign hit_ex_a_s = ex_collision_a & id_use_a & ~id_req_a_zero & ex_wen_q;
   assign hit_dm_a_s = dm_collision_a & id_use_a & ~id_req_a_zero & dm_wen_q;
   assign hit_ex_b_s = ex_collision_b & id_use_b & ~id_req_b_zero & ex_wen_q;
   assign hit_dm_b_s = dm_collision_b & id_use_b & ~id_req_b_zero & dm_wen_q;

   assign run_s  = (state_q == ST_RUN);
   // A flushed ID instruction never needs its operand, so it never stalls.
   assign lu_s   = run_s & ex_load_q & (hit_ex_a_s | hit_ex_b_s) & ~flush;
   assign kill_s = lu_s | flush;

   // Output decode; while rst is high everything is forced to its idle value.
   always_comb begin
      fwd_sel_a = 2'd0;
      fwd_sel_b = 2'd0;
      stall     = 1'b0;
      bubble    = 1'b0;
      pipe_en   = 1'b1;
      if (rst) begin
         fwd_sel_a = 2'd0;
         fwd_sel_b = 2'd0;
         stall     = 1'b0;
         bubble    = 1'b0;
         pipe_en   = 1'b1;
      end else begin
         // EX holds the youngest value, so it wins over DM.
         if (hit_ex_a_s) begin
            fwd_sel_a = 2'd1;
         end else if (hit_dm_a_s) begin
            fwd_sel_a = 2'd2;
         end else begin
            fwd_sel_a = 2'd0;
         end
         if (hit_ex_b_s) begin
            fwd_sel_b = 2'd1;
         end else if (hit_dm_b_s) begin
            fwd_sel_b = 2'd2;
         end else begin
            fwd_sel_b = 2'd0;
         end
         stall   = lu_s | ~run_s;
         bubble  = lu_s;
         pipe_en = run_s;
      end
   end

   // Next-state: shift tracking while running, count down the load wait otherwise.
   always_comb begin
      ex_wen_d  = ex_wen_q;
      ex_load_d = ex_load_q;
      dm_wen_d  = dm_wen_q;
      dm_load_d = dm_load_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_RUN: begin
            dm_wen_d  = ex_wen_q;
            dm_load_d = ex_load_q;
            ex_wen_d  = id_wen & ~kill_s;
            ex_load_d = id_is_load & ~kill_s;
            if (ex_load_q & ex_wen_q & (MEM_WAIT_C != CNT_ZERO)) begin
               state_d = ST_WAIT;
               cnt_d   = MEM_WAIT_C;
            end else begin
               state_d = ST_RUN;
               cnt_d   = cnt_q;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_wen_q  <= 1'b0;
         ex_load_q <= 1'b0;
         dm_wen_q  <= 1'b0;
         dm_load_q <= 1'b0;
         state_q   <= ST_RUN;
         cnt_q     <= CNT_ZERO;
      end else begin
         ex_wen_q  <= ex_wen_d;
         ex_load_q <= ex_load_d;
         dm_wen_q  <= dm_wen_d;
         dm_load_q <= dm_load_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_resolver.sv
// tb_hazard_resolver
// Two instances (MEM_WAIT = 0 and MEM_WAIT = 2) share one stimulus stream.
// A slot-based reference model predicts both every cycle; a constant vector
// table and hand-written sequences pin down the documented corner cases.

module tb_hazard_resolver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, use_a, use_b, za, zb, wen, ld, flush, eca, dca, ecb, dcb;
   logic [1:0] fa0, fb0, fa2, fb2;
   logic st0, bu0, pe0, st2, bu2, pe2;

   hazard_resolver #(.MEM_WAIT(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .id_use_a(use_a), .id_use_b(use_b),
      .id_req_a_zero(za), .id_req_b_zero(zb), .id_wen(wen), .id_is_load(ld),
      .flush(flush), .ex_collision_a(eca), .dm_collision_a(dca),
      .ex_collision_b(ecb), .dm_collision_b(dcb),
      .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall(st0), .bubble(bu0), .pipe_en(pe0));

   hazard_resolver #(.MEM_WAIT(2), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .id_use_a(use_a), .id_use_b(use_b),
      .id_req_a_zero(za), .id_req_b_zero(zb), .id_wen(wen), .id_is_load(ld),
      .flush(flush), .ex_collision_a(eca), .dm_collision_a(dca),
      .ex_collision_b(ecb), .dm_collision_b(dcb),
      .fwd_sel_a(fa2), .fwd_sel_b(fb2), .stall(st2), .bubble(bu2), .pipe_en(pe2));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { bit wen; bit load; } slot_t;
   slot_t m_ex[2];
   slot_t m_dm[2];
   int    m_wait[2];          // remaining frozen cycles
   int    mw[2];
   int    e_fa[2], e_fb[2], e_st[2], e_bu[2], e_pe[2];
   bit    e_lu[2];

   task automatic model_eval(input int k);
      bit ra, rb, hxa, hxb, hda, hdb, frozen, lu;
      ra  = use_a && !za;
      rb  = use_b && !zb;
      hxa = eca && ra && m_ex[k].wen;
      hda = dca && ra && m_dm[k].wen;
      hxb = ecb && rb && m_ex[k].wen;
      hdb = dcb && rb && m_dm[k].wen;
      frozen = (m_wait[k] > 0);
      lu = !frozen && m_ex[k].load && (hxa || hxb) && !flush;
      if (rst) begin
         e_fa[k] = 0; e_fb[k] = 0; e_st[k] = 0; e_bu[k] = 0; e_pe[k] = 1;
         lu = 1'b0;
      end else begin
         e_fa[k] = hxa ? 1 : (hda ? 2 : 0);
         e_fb[k] = hxb ? 1 : (hdb ? 2 : 0);
         e_st[k] = (frozen || lu) ? 1 : 0;
         e_bu[k] = lu ? 1 : 0;
         e_pe[k] = frozen ? 0 : 1;
      end
      e_lu[k] = lu;
   endtask

   task automatic model_clock(input int k);
      bit kill;
      if (rst) begin
         m_ex[k] = '{0, 0}; m_dm[k] = '{0, 0}; m_wait[k] = 0;
      end else if (m_wait[k] > 0) begin
         m_wait[k] = m_wait[k] - 1;
      end else begin
         if (m_ex[k].load && m_ex[k].wen && mw[k] > 0) m_wait[k] = mw[k];
         kill = e_lu[k] || flush;
         m_dm[k] = m_ex[k];
         m_ex[k].wen  = wen && !kill;
         m_ex[k].load = ld && !kill;
      end
   endtask

   // One cycle: inputs already driven; check both DUTs, then clock the model.
   task automatic step();
      #2;
      for (int k = 0; k < 2; k++) model_eval(k);
      chk("m0.fwd_a", fa0, e_fa[0]); chk("m0.fwd_b", fb0, e_fb[0]);
      chk("m0.stall", st0, e_st[0]); chk("m0.bubble", bu0, e_bu[0]);
      chk("m0.pipe_en", pe0, e_pe[0]);
      chk("m2.fwd_a", fa2, e_fa[1]); chk("m2.fwd_b", fb2, e_fb[1]);
      chk("m2.stall", st2, e_st[1]); chk("m2.bubble", bu2, e_bu[1]);
      chk("m2.pipe_en", pe2, e_pe[1]);
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_clock(k);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      {rst, use_a, use_b, za, zb, wen, ld, flush, eca, dca, ecb, dcb} = 12'b0;
   endtask

   // ---------------- vector table (MEM_WAIT = 0 instance) ----------------
   // in = {rst,use_a,use_b,za,zb,wen,ld,flush,eca,dca,ecb,dcb}
   typedef struct {
      logic [11:0] in;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        st;
      logic        bu;
      logic        pe;
   } vec_t;
   vec_t tv[15];

   initial begin
      mw[0] = 0; mw[1] = 2;
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = '{0, 0}; m_dm[k] = '{0, 0}; m_wait[k] = 0;
      end

      tv[0]  = '{12'b1110_0110_1111, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // reset, all ones
      tv[1]  = '{12'b1110_0110_1111, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
      tv[2]  = '{12'b0110_0000_1111, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // just out of reset
      tv[3]  = '{12'b0000_0100_0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // ALU writer
      tv[4]  = '{12'b0100_0000_1100, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1}; // EX beats DM
      tv[5]  = '{12'b0100_0000_0100, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1}; // DM only
      tv[6]  = '{12'b0000_0110_0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // load
      tv[7]  = '{12'b0010_0000_0010, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1}; // load-use
      tv[8]  = '{12'b0010_0000_0001, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1}; // forwarded from DM
      tv[9]  = '{12'b0000_0110_0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // load
      tv[10] = '{12'b0101_0000_1000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // $0 read
      tv[11] = '{12'b0000_0000_0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
      tv[12] = '{12'b0000_0110_0000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // load
      tv[13] = '{12'b0100_0101_1000, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1}; // load-use + flush
      tv[14] = '{12'b0110_0000_1010, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}; // killed writer

      for (int i = 0; i < 15; i++) begin
         {rst, use_a, use_b, za, zb, wen, ld, flush, eca, dca, ecb, dcb} = tv[i].in;
         #2;
         chk($sformatf("tv%0d.fwd_a", i), fa0, tv[i].fa);
         chk($sformatf("tv%0d.fwd_b", i), fb0, tv[i].fb);
         chk($sformatf("tv%0d.stall", i), st0, tv[i].st);
         chk($sformatf("tv%0d.bubble", i), bu0, tv[i].bu);
         chk($sformatf("tv%0d.pipe_en", i), pe0, tv[i].pe);
         step();
      end

      // ---- slow load on MEM_WAIT = 2 instance: freeze, hold, resume ----
      idle_inputs(); rst = 1'b1; step();
      idle_inputs(); wen = 1'b1; ld = 1'b1; step();      // load enters EX
      idle_inputs(); #2;
      chk("mw2.load_in_ex.pipe_en", pe2, 1); step();
      idle_inputs(); wen = 1'b1; #2;                       // ID writer must not be captured
      chk("mw2.wait1.pipe_en", pe2, 0); chk("mw2.wait1.stall", st2, 1);
      chk("mw2.wait1.bubble", bu2, 0); step();
      idle_inputs(); wen = 1'b1; #2;
      chk("mw2.wait2.pipe_en", pe2, 0); chk("mw2.wait2.stall", st2, 1); step();
      idle_inputs(); use_a = 1'b1; eca = 1'b1; dca = 1'b1; #2;
      chk("mw2.resume.pipe_en", pe2, 1); chk("mw2.resume.stall", st2, 0);
      chk("mw2.resume.fwd_a", fa2, 2); step();

      // ---- reset during the first frozen cycle ----
      idle_inputs(); wen = 1'b1; ld = 1'b1; step();
      idle_inputs(); step();
      idle_inputs(); rst = 1'b1; step();
      idle_inputs(); #2;
      chk("mw2.after_rst.pipe_en", pe2, 1); chk("mw2.after_rst.stall", st2, 0); step();

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 39) == 0);
         use_a = $urandom_range(0, 1) != 0;
         use_b = $urandom_range(0, 1) != 0;
         za    = ($urandom_range(0, 3) == 0);
         zb    = ($urandom_range(0, 3) == 0);
         wen   = $urandom_range(0, 3) != 0;
         ld    = $urandom_range(0, 2) == 0;
         flush = ($urandom_range(0, 5) == 0);
         eca   = $urandom_range(0, 1) != 0;
         dca   = $urandom_range(0, 1) != 0;
         ecb   = $urandom_range(0, 1) != 0;
         dcb   = $urandom_range(0, 1) != 0;
         step();
      end

      // ---- all-ones collisions with no operand use ----
      idle_inputs(); {eca, dca, ecb, dcb} = 4'b1111; #2;
      chk("nouse.fwd_a", fa0, 0); chk("nouse.fwd_b", fb0, 0); chk("nouse.stall", st0, 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
